summator_ctrl: RTL and testbench

Board-level sequencer for the 8-bit summator datapath. It captures operand A, then operand B, from the slide switches on debounced key presses, and performs an unsigned add or subtract. It then shows the result on the green LEDs and seven-segment displays, with a carry/borrow flag and a running count of completed operations. It sits directly under the board top, between the raw key/switch pins and the LED/HEX pins.

---
 rtl/summator_pkg.sv | 8 +
 rtl/hex2sev_segm.sv | 30 +++
 rtl/summator_ctrl_key_press.sv | 32 +++
 rtl/summator_ctrl.sv | 63 ++++++
 tb/tb_summator_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/summator_pkg.sv
// summator_pkg: shared state encoding, operation codes and display constants
package summator_pkg;
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_RES = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int DATA_W = 8;
  localparam logic [6:0] SEG_BLANK_ERR = 7'b0111111;
endpackage

// File: rtl/hex2sev_segm.sv
// hex2sev_segm: 4-bit value to active-low seven-segment pattern (gfedcba)
module hex2sev_segm
  import summator_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK_ERR;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK_ERR;
    endcase
  end
endmodule

// File: rtl/summator_ctrl_key_press.sv
// key_press: synchronise and debounce an active-low key, emit one pulse per accepted press
module key_press #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic level, level_d, synced, accept;
  assign synced = sync[SYNC_STAGES-1];
  assign accept = (synced != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      cnt <= '0;
      level <= 1'b1;
      level_d <= 1'b1;
      press <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, key});
      cnt <= (synced == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? synced : level;
      level_d <= level;
      press <= level_d & ~level;
    end
  end
endmodule

// File: rtl/summator_ctrl.sv
// summator_ctrl: key-driven A/B capture, add/sub, LED and seven-segment result display
module summator_ctrl
  import summator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button1,
  input  logic              button2,
  input  logic [DATA_W-1:0] switch1,
  output logic [DATA_W-1:0] ledR1,
  output logic              ledR17,
  output logic [DATA_W-1:0] ledG,
  output logic              ledG8,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic [6:0]        hex6,
  output logic [6:0]        hex7
);
  state_t state, state_n;
  logic op, op_n, load, opp;
  logic [DATA_W-1:0] opa, opa_n, ops_cnt, ops_n, disp;
  logic [DATA_W:0] result, result_n;
  key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
    u_load (.clk(clk), .rst_n(rst_n), .key(button1), .press(load));
  key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
    u_op (.clk(clk), .rst_n(rst_n), .key(button2), .press(opp));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_A;
      op <= OP_ADD;
      opa <= '0;
      result <= '0;
      ops_cnt <= '0;
    end else begin
      state <= state_n;
      op <= op_n;
      opa <= opa_n;
      result <= result_n;
      ops_cnt <= ops_n;
    end
  end
  // op toggles before the result is formed, so a coincident OP press applies to this result
  always_comb begin
    op_n = (opp && state != S_RES) ? ~op : op;
    state_n = !load ? state : state == S_A ? S_B : state == S_B ? S_RES : S_A;
    opa_n = (load && state == S_A) ? switch1 : opa;
    result_n = !(load && state == S_B) ? result :
               op_n == OP_SUB ? {1'b0, opa} - {1'b0, switch1} : {1'b0, opa} + {1'b0, switch1};
    ops_n = (load && state == S_B) ? ops_cnt + 1'b1 : ops_cnt;
  end
  assign ledR1 = switch1;
  assign ledR17 = op;
  assign ledG = state == S_RES ? result[DATA_W-1:0] : '0;
  assign ledG8 = state == S_RES && result[DATA_W];
  assign disp = state == S_RES ? result[DATA_W-1:0] : switch1;
  hex2sev_segm u_hex4 (.hex(disp[3:0]), .seg(hex4));
  hex2sev_segm u_hex5 (.hex(disp[7:4]), .seg(hex5));
  hex2sev_segm u_hex6 (.hex(ops_cnt[3:0]), .seg(hex6));
  hex2sev_segm u_hex7 (.hex(ops_cnt[7:4]), .seg(hex7));
endmodule

// File: tb/tb_summator_ctrl.sv
// tb_summator_ctrl: randomized key sequences checked against a behavioural summator model
module tb_summator_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, button1 = 1'b1, button2 = 1'b1;
  logic [7:0] switch1 = 8'h00;
  logic [7:0] ledR1, ledG;
  logic ledR17, ledG8;
  logic [6:0] hex4, hex5, hex6, hex7;
  int total = 0, bad = 0;
  int mstate = 0, mop = 0, mopa = 0, mres = 0, mflag = 0, mcnt = 0;
  summator_ctrl #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .button1(button1), .button2(button2), .switch1(switch1),
    .ledR1(ledR1), .ledR17(ledR17), .ledG(ledG), .ledG8(ledG8),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] seg(input int v);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v & 15];
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic model_load();
    int s;
    if (mstate == 0) begin
      mopa = switch1;
      mstate = 1;
    end else if (mstate == 1) begin
      s = mop ? mopa - int'(switch1) : mopa + int'(switch1);
      mres = s & 255;
      mflag = mop ? int'(mopa < int'(switch1)) : int'(s > 255);
      mcnt = (mcnt + 1) % 256;
      mstate = 2;
    end else mstate = 0;
  endtask
  task automatic press(input bit l, input bit o);
    if (l) button1 = 1'b0;
    if (o) button2 = 1'b0;
    cyc(8);
    button1 = 1'b1;
    button2 = 1'b1;
    cyc(8);
    if (o && mstate != 2) mop ^= 1;
    if (l) model_load();
  endtask
  task automatic check_all(input string tag);
    int d;
    @(negedge clk);
    d = mstate == 2 ? mres : int'(switch1);
    chk({tag, ".ledR1"}, ledR1, switch1);
    chk({tag, ".ledR17"}, ledR17, mop);
    chk({tag, ".ledG"}, ledG, mstate == 2 ? mres : 0);
    chk({tag, ".ledG8"}, ledG8, mstate == 2 ? mflag : 0);
    chk({tag, ".hex4"}, hex4, seg(d));
    chk({tag, ".hex5"}, hex5, seg(d >> 4));
    chk({tag, ".hex6"}, hex6, seg(mcnt));
    chk({tag, ".hex7"}, hex7, seg(mcnt >> 4));
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    mstate = 0; mop = 0; mopa = 0; mres = 0; mflag = 0; mcnt = 0;
    cyc(1);
  endtask
  initial begin
    int n;
    int r;
    do_reset();
    switch1 = 8'hA7;
    check_all("reset");
    chk("reset.hex6_zero", hex6, 7'b1000000);
    switch1 = 8'h3C; press(1, 0);
    switch1 = 8'h15; press(1, 0);
    check_all("add1");
    chk("add1.ledG", ledG, 8'h51);
    chk("add1.hex5", hex5, 7'b0010010);
    chk("add1.hex4", hex4, 7'b1111001);
    chk("add1.hex6", hex6, 7'b1111001);
    press(1, 0);
    switch1 = 8'hF0; press(1, 0);
    switch1 = 8'h20; press(1, 0);
    check_all("carry");
    chk("carry.ledG8", ledG8, 1'b1);
    press(1, 0);
    press(0, 1);
    check_all("op_sa");
    chk("op_sa.ledR17", ledR17, 1'b1);
    switch1 = 8'h10; press(1, 0);
    switch1 = 8'h20; press(1, 0);
    check_all("borrow");
    chk("borrow.ledG", ledG, 8'hF0);
    press(0, 1);
    check_all("op_sres");
    chk("op_sres.ledR17", ledR17, 1'b1);
    press(1, 0);
    switch1 = 8'h55; press(1, 0);
    switch1 = 8'h22; press(1, 1);
    check_all("both");
    press(1, 0);
    switch1 = 8'h11; press(1, 0);
    switch1 = 8'h01;
    for (int i = 0; i < 10; i++) begin
      button1 = i[0];
      cyc(2);
    end
    check_all("bounce_quiet");
    button1 = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ledG !== 8'h00) break;
    end
    chk("bounce.latency", n, 8);
    cyc(30);
    button1 = 1'b1;
    cyc(10);
    model_load();
    check_all("bounce_one");
    button1 = 1'b0;
    cyc(3);
    button1 = 1'b1;
    cyc(15);
    check_all("glitch");
    press(1, 0);
    for (int i = 0; i < 40; i++) begin
      switch1 = 8'($urandom);
      r = $urandom_range(0, 7);
      press(r < 6, r >= 4);
      check_all("rand");
    end
    while (mstate != 1) press(1, 0);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    mstate = 0; mop = 0; mopa = 0; mres = 0; mflag = 0; mcnt = 0;
    cyc(1);
    check_all("mid_reset");
    for (int i = 0; i < 256; i++) begin
      switch1 = 8'($urandom);
      press(1, 0);
      switch1 = 8'($urandom);
      press(1, 0);
      if (i == 254 || i == 255) check_all("wrap");
      press(1, 0);
    end
    chk("wrap.hex6", hex6, 7'b1000000);
    chk("wrap.hex7", hex7, 7'b1000000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
